// File: rtl/sockit_spi_arb.sv
// Packet-level round-robin arbiter feeding the command CDC FIFO; the grant is locked for a whole packet.
// Optional build macro SOCKIT_SPI_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module sockit_spi_arb #(
    parameter  int RN = 2,
    parameter  int DW = 32,
    localparam int GW = (RN > 1) ? $clog2(RN) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [RN-1:0]    req_vld,
    input  logic [RN-1:0]    req_lst,
    input  logic [RN*DW-1:0] req_dat,
    output logic [RN-1:0]    req_rdy,
    output logic             out_vld,
    output logic             out_lst,
    output logic [DW-1:0]    out_dat,
    input  logic             out_rdy,
    output logic [GW-1:0]    out_gnt,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t          state;
    logic [GW-1:0]   gnt;
    logic [GW-1:0]   ptr;
    logic [GW-1:0]   winner;
    logic            ld;
    logic            xfer;
    logic            sel_lst;
    logic [DW-1:0]   sel_dat;

    // Winner search; the candidate closest after 'from' is assigned last and therefore wins.
    function automatic logic [GW-1:0] pick(input logic [RN-1:0] vld, input logic [GW-1:0] from);
        logic [GW-1:0] w;
        logic [GW-1:0] idx;
        w = from;
`ifdef SOCKIT_SPI_ARB_FIXED_PRIO_EN
        for (int i = RN - 1; i >= 0; i--) begin
            idx = GW'(i);
            if (vld[idx]) w = idx;
        end
`else
        for (int k = RN; k >= 1; k--) begin
            idx = GW'((int'(from) + k) % RN);
            if (vld[idx]) w = idx;
        end
`endif
        return w;
    endfunction

    // Ready toward the owning requester, granted-beat mux and arbitration result.
    always_comb begin
        ld      = ~out_vld | out_rdy;
        req_rdy = '0;
        for (int i = 0; i < RN; i++) begin
            req_rdy[i] = (state == LOCK) && (gnt == GW'(i)) && ld && !clr;
        end
        xfer    = |(req_rdy & req_vld);
        sel_dat = req_dat[int'(gnt)*DW +: DW];
        sel_lst = req_lst[gnt];
        winner  = pick(req_vld, ptr);
    end

    // Output stage and IDLE/LOCK state machine; clr aborts the packet but keeps ptr.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= '0;
            ptr     <= GW'(RN - 1);
            out_vld <= 1'b0;
            out_lst <= 1'b0;
            out_dat <= '0;
            out_gnt <= '0;
        end else if (clr) begin
            state   <= IDLE;
            out_vld <= 1'b0;
        end else begin
            if (xfer) begin
                out_vld <= 1'b1;
                out_dat <= sel_dat;
                out_lst <= sel_lst;
                out_gnt <= gnt;
            end else if (out_rdy) begin
                out_vld <= 1'b0;
            end else begin
                out_vld <= out_vld;
            end
            case (state)
                IDLE: begin
                    if (|req_vld) begin
                        gnt   <= winner;
                        state <= LOCK;
                    end else begin
                        state <= IDLE;
                    end
                end
                LOCK: begin
                    if (xfer && sel_lst) begin
                        state <= IDLE;
`ifndef SOCKIT_SPI_ARB_FIXED_PRIO_EN
                        ptr   <= gnt;
`endif
                    end else begin
                        state <= LOCK;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == LOCK) | out_vld;

endmodule
